// File: rtl/ca_search_controller_if.sv
// Handshake bundle between the acquisition sequencer and its neighbours:
// search control, chip-rate divider, C/A generator and correlator.
interface ca_search_controller_if #(
  parameter int ACC_WIDTH = 16
);
  logic                 start;
  logic                 abort;
  logic [4:0]           prn_first;
  logic [4:0]           prn_last;
  logic                 chip_tick;
  logic                 ca_reset;
  logic                 ca_clock_en;
  logic [4:0]           ca_prn;
  logic                 corr_dump;
  logic                 corr_valid;
  logic [ACC_WIDTH-1:0] corr_power;
  logic                 busy;
  logic                 done;
  logic [4:0]           best_prn;
  logic [9:0]           best_phase;
  logic [ACC_WIDTH-1:0] best_power;

  modport slave (
    input  start, abort, prn_first, prn_last, chip_tick, corr_valid, corr_power,
    output ca_reset, ca_clock_en, ca_prn, corr_dump, busy, done,
           best_prn, best_phase, best_power
  );

  modport master (
    output start, abort, prn_first, prn_last, chip_tick, corr_valid, corr_power,
    input  ca_reset, ca_clock_en, ca_prn, corr_dump, busy, done,
           best_prn, best_phase, best_power
  );
endinterface

// File: rtl/ca_search_controller.sv
// C/A acquisition sequencer: walks every (PRN, phase) hypothesis, slews and
// dwells the generator, dumps the correlator and keeps the strongest result.
module ca_search_controller #(
  parameter int CHIPS_PER_CODE = 1023,
  parameter int PHASE_STEP     = 1,
  parameter int DWELL_EPOCHS   = 1,
  parameter int ACC_WIDTH      = 16
) (
  input logic                   clock,
  input logic                   reset_n,
  ca_search_controller_if.slave bus
);
  localparam int CNT_W = 14;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_EPOCHS * CHIPS_PER_CODE - 1);
  localparam logic [10:0]      STEP       = 11'(PHASE_STEP);
  localparam logic [10:0]      CPC        = 11'(CHIPS_PER_CODE);

  typedef enum logic [3:0] {
    IDLE, LOAD, SLEW, DWELL, DUMP, WAIT, COMPARE, NEXT, DONE
  } state_t;

  state_t               state, state_n;
  logic [5:0]           prn, prn_n, prn_inc;
  logic [4:0]           prn_last_q, prn_last_n;
  logic [9:0]           phase, phase_n;
  logic [10:0]          phase_inc;
  logic [9:0]           slew_cnt, slew_cnt_n;
  logic [CNT_W-1:0]     chip_cnt, chip_cnt_n;
  logic [ACC_WIDTH-1:0] power_q, power_n;
  logic                 best_clr, best_upd;

  logic                 ca_reset_q, ca_clock_en_q, corr_dump_q, busy_q, done_q;
  logic [4:0]           ca_prn_q, best_prn_q;
  logic [9:0]           best_phase_q;
  logic [ACC_WIDTH-1:0] best_power_q;

  always_comb begin
    state_n    = state;
    prn_n      = prn;
    prn_last_n = prn_last_q;
    phase_n    = phase;
    slew_cnt_n = slew_cnt;
    chip_cnt_n = chip_cnt;
    power_n    = power_q;
    best_clr   = 1'b0;
    best_upd   = 1'b0;
    phase_inc  = {1'b0, phase} + STEP;
    prn_inc    = prn + 6'd1;
    case (state)
      IDLE: if (bus.start) begin
        prn_n      = {1'b0, bus.prn_first};
        prn_last_n = bus.prn_last;
        phase_n    = '0;
        best_clr   = 1'b1;
        state_n    = (bus.prn_first > bus.prn_last) ? DONE : LOAD;
      end
      LOAD: begin
        chip_cnt_n = '0;
        slew_cnt_n = phase;
        state_n    = (phase == '0) ? DWELL : SLEW;
      end
      SLEW: begin
        slew_cnt_n = slew_cnt - 10'd1;
        if (slew_cnt == 10'd1) state_n = DWELL;
      end
      DWELL: if (bus.chip_tick) begin
        if (chip_cnt == DWELL_LAST) state_n = DUMP;
        else chip_cnt_n = chip_cnt + CNT_W'(1);
      end
      DUMP: state_n = WAIT;
      WAIT: if (bus.corr_valid) begin
        power_n = bus.corr_power;
        state_n = COMPARE;
      end
      COMPARE: begin
        best_upd = (power_q > best_power_q);
        state_n  = NEXT;
      end
      NEXT: begin
        // 6-bit PRN so that prn_last = 31 ends the search instead of wrapping
        if (phase_inc >= CPC) begin
          phase_n = '0;
          prn_n   = prn_inc;
          state_n = (prn_inc > {1'b0, prn_last_q}) ? DONE : LOAD;
        end else begin
          phase_n = phase_inc[9:0];
          state_n = LOAD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && bus.abort) begin
      state_n  = IDLE;
      best_upd = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      prn           <= '0;
      prn_last_q    <= '0;
      phase         <= '0;
      slew_cnt      <= '0;
      chip_cnt      <= '0;
      power_q       <= '0;
      ca_reset_q    <= 1'b1;
      ca_clock_en_q <= 1'b0;
      ca_prn_q      <= '0;
      corr_dump_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      best_prn_q    <= '0;
      best_phase_q  <= '0;
      best_power_q  <= '0;
    end else begin
      state         <= state_n;
      prn           <= prn_n;
      prn_last_q    <= prn_last_n;
      phase         <= phase_n;
      slew_cnt      <= slew_cnt_n;
      chip_cnt      <= chip_cnt_n;
      power_q       <= power_n;
      // outputs registered from the next state so they line up with it
      ca_reset_q    <= (state_n == IDLE) || (state_n == LOAD);
      ca_clock_en_q <= (state_n == SLEW) ||
                       (state == DWELL && bus.chip_tick && state_n != IDLE);
      if (state_n == LOAD) ca_prn_q <= prn_n[4:0];
      corr_dump_q   <= (state_n == DUMP);
      busy_q        <= (state_n != IDLE);
      done_q        <= (state_n == DONE);
      if (best_clr) begin
        best_prn_q   <= '0;
        best_phase_q <= '0;
        best_power_q <= '0;
      end else if (best_upd) begin
        best_prn_q   <= prn[4:0];
        best_phase_q <= phase;
        best_power_q <= power_q;
      end
    end
  end

  assign bus.ca_reset    = ca_reset_q;
  assign bus.ca_clock_en = ca_clock_en_q;
  assign bus.ca_prn      = ca_prn_q;
  assign bus.corr_dump   = corr_dump_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.best_prn    = best_prn_q;
  assign bus.best_phase  = best_phase_q;
  assign bus.best_power  = best_power_q;
endmodule

// File: tb/tb_ca_search_controller.sv
// Randomised bench for ca_search_controller: hypothesis list, correlator
// replies and expected best result come from a list-based model.
module tb_ca_search_controller;
  localparam int CPC         = 8;
  localparam int STEP        = 2;
  localparam int DWELL       = 2;
  localparam int ACC         = 16;
  localparam int DWELL_CHIPS = DWELL * CPC;
  localparam int BUDGET      = 8000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ca_search_controller_if #(.ACC_WIDTH(ACC)) bus();

  ca_search_controller #(
    .CHIPS_PER_CODE(CPC), .PHASE_STEP(STEP), .DWELL_EPOCHS(DWELL), .ACC_WIDTH(ACC)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  int n_checks = 0, n_fail = 0;
  int tick_pct = 50;
  int corr_k = 2, corr_limit = 1 << 30, corr_d = 0;
  int stray_max = 0, stray_cnt = 0;
  int hyp_base = 0;
  int en_cnt = 0, run_cnt = 0, last_run = 0, done_cnt = 0, overlap_err = 0;
  bit run_open = 1'b0;
  int obs_prn[$], obs_en[$], obs_run[$];
  int exp_prn[$], exp_ph[$];
  logic [15:0] exp_pw[$];
  logic [15:0] pw [32][CPC];

  // chip-rate divider stand-in
  initial begin
    bus.chip_tick = 1'b0;
    forever begin
      @(posedge clock);
      #1 bus.chip_tick = ($urandom_range(99, 0) < tick_pct);
    end
  end

  // observer: generator pulses since load, slew run length, dumps, done
  initial begin
    forever begin
      @(negedge clock);
      if (bus.ca_reset && bus.ca_clock_en) overlap_err++;
      if (bus.ca_reset) begin
        en_cnt = 0; run_cnt = 0; run_open = 1'b1;
      end else begin
        if (bus.ca_clock_en) en_cnt++;
        if (run_open) begin
          if (bus.ca_clock_en) run_cnt++;
          else begin last_run = run_cnt; run_open = 1'b0; end
        end
      end
      if (bus.corr_dump) begin
        obs_prn.push_back(int'(bus.ca_prn));
        obs_en.push_back(en_cnt);
        obs_run.push_back(last_run);
      end
      if (bus.done) done_cnt++;
    end
  end

  // correlator model: answers the d-th dump of a search with the planned power
  initial begin
    bus.corr_valid = 1'b0;
    bus.corr_power = '0;
    forever begin
      @(negedge clock);
      if (bus.corr_dump) begin
        int d;
        d = corr_d - hyp_base;
        corr_d++;
        if (d >= 0 && d < corr_limit && d < exp_pw.size()) begin
          repeat (corr_k) @(posedge clock);
          #1 bus.corr_valid = 1'b1; bus.corr_power = exp_pw[d];
          @(posedge clock);
          #1 bus.corr_valid = 1'b0; bus.corr_power = 16'($urandom);
        end
      end else if (stray_cnt < stray_max && bus.busy && !bus.ca_reset &&
                   en_cnt >= 9 && en_cnt <= 11) begin
        @(posedge clock);
        #1 bus.corr_valid = 1'b1; bus.corr_power = 16'hFFFF;
        @(posedge clock);
        #1 bus.corr_valid = 1'b0;
        stray_cnt++;
      end
    end
  end

  task automatic fill_pw(input int lo, input int hi);
    for (int p = 0; p < 32; p++)
      for (int ph = 0; ph < CPC; ph++) pw[p][ph] = 16'($urandom_range(hi, lo));
  endtask

  task automatic plan(input int first, input int last);
    exp_prn.delete(); exp_ph.delete(); exp_pw.delete();
    hyp_base = obs_prn.size();
    for (int p = first; p <= last; p++)
      for (int ph = 0; ph < CPC; ph += STEP) begin
        exp_prn.push_back(p); exp_ph.push_back(ph); exp_pw.push_back(pw[p][ph]);
      end
  endtask

  task automatic model_best(input int n, output int bprn, output int bph, output int bpw);
    bprn = 0; bph = 0; bpw = 0;
    for (int d = 0; d < n; d++)
      if (int'(exp_pw[d]) > bpw) begin
        bprn = exp_prn[d]; bph = exp_ph[d]; bpw = int'(exp_pw[d]);
      end
  endtask

  function automatic int hyp_bad(input int n);
    int bad = 0;
    for (int d = 0; d < n; d++) begin
      int idx = hyp_base + d;
      if (idx >= obs_prn.size()) bad++;
      else if (obs_prn[idx] != exp_prn[d] || obs_en[idx] != exp_ph[d] + DWELL_CHIPS ||
               obs_run[idx] != exp_ph[d]) bad++;
    end
    return bad;
  endfunction

  task automatic pulse_start(input int first, input int last);
    @(posedge clock);
    #1 bus.start = 1'b1; bus.prn_first = 5'(first); bus.prn_last = 5'(last);
    @(posedge clock);
    #1 bus.start = 1'b0; bus.prn_first = 5'($urandom); bus.prn_last = 5'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clock);
      if (bus.done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    repeat (2) @(negedge clock);
    n_checks++;
    if (bus.ca_reset !== 1'b1 || bus.busy !== 1'b0 || bus.ca_clock_en !== 1'b0 ||
        bus.corr_dump !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rst=%b busy=%b en=%b dump=%b done=%b, want 1 0 0 0 0",
               bus.ca_reset, bus.busy, bus.ca_clock_en, bus.corr_dump, bus.done);
    end
    n_checks++;
    if (bus.ca_prn !== 5'd0 || bus.best_prn !== 5'd0 || bus.best_phase !== 10'd0 ||
        bus.best_power !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got prn=%0d best=%0d/%0d/%0d, want all 0",
               bus.ca_prn, bus.best_prn, bus.best_phase, bus.best_power);
    end
    @(posedge clock); #1 reset_n = 1'b1;

    fill_pw(1, 10); pw[9][0] = 16'd20;
    plan(9, 9);
    tick_pct = 60; corr_k = 1;
    pulse_start(9, 9);
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(posedge clock);
      if (obs_prn.size() > hyp_base) ok = 1'b1;
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < BUDGET && !ok; i++) begin
        @(negedge clock);
        if (bus.ca_reset && bus.busy) ok = 1'b1;
      end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < BUDGET && !ok; i++) begin
        @(posedge clock);
        if (en_cnt >= 9) ok = 1'b1;
      end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_reach_dwell: timed out, want second dwell"); end
    n_checks++;
    if (bus.best_power !== 16'd20 || bus.best_prn !== 5'd9) begin
      n_fail++;
      $display("FAIL reset_pre_best: got %0d/%0d, want 9/20", bus.best_prn, bus.best_power);
    end
    #2 reset_n = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.ca_reset !== 1'b1 || bus.busy !== 1'b0 || bus.ca_clock_en !== 1'b0 ||
        bus.best_power !== 16'd0 || bus.ca_prn !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_dwell: got rst=%b busy=%b en=%b pow=%0d prn=%0d, want 1 0 0 0 0",
               bus.ca_reset, bus.busy, bus.ca_clock_en, bus.best_power, bus.ca_prn);
    end
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_single();
    bit ok; int dc0, mp, mh, mw;
    fill_pw(1, 50);
    plan(5, 5);
    tick_pct = 40; corr_k = 2; dc0 = done_cnt;
    pulse_start(5, 5);
    wait_done(ok);
    repeat (3) @(negedge clock);
    model_best(exp_pw.size(), mp, mh, mw);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_done: timed out waiting for done"); end
    n_checks++;
    if (obs_prn.size() - hyp_base !== 4) begin
      n_fail++; $display("FAIL single_dumps: got %0d, want 4", obs_prn.size() - hyp_base);
    end
    n_checks++;
    if (hyp_bad(4) !== 0) begin
      n_fail++; $display("FAIL single_hyps: %0d bad hypotheses, want 0", hyp_bad(4));
    end
    n_checks++;
    if (done_cnt - dc0 !== 1) begin
      n_fail++; $display("FAIL single_done_cnt: got %0d, want 1", done_cnt - dc0);
    end
    n_checks++;
    if (bus.best_prn !== 5'(mp) || bus.best_phase !== 10'(mh) || bus.best_power !== 16'(mw)) begin
      n_fail++;
      $display("FAIL single_best: got %0d/%0d/%0d, want %0d/%0d/%0d",
               bus.best_prn, bus.best_phase, bus.best_power, mp, mh, mw);
    end
  endtask

  task automatic test_slew_order();
    bit ok;
    fill_pw(0, 99); pw[1][6] = 16'd100;
    plan(0, 1);
    tick_pct = 100; corr_k = 1;
    pulse_start(0, 1);
    wait_done(ok);
    repeat (2) @(negedge clock);
    n_checks++;
    if (!ok || obs_prn.size() - hyp_base !== 8) begin
      n_fail++; $display("FAIL slew_dumps: got %0d (done=%b), want 8", obs_prn.size() - hyp_base, ok);
    end
    n_checks++;
    if (hyp_bad(8) !== 0) begin
      n_fail++; $display("FAIL slew_hyps: %0d bad hypotheses (order/slew/dwell), want 0", hyp_bad(8));
    end
    n_checks++;
    if (bus.best_prn !== 5'd1 || bus.best_phase !== 10'd6 || bus.best_power !== 16'd100) begin
      n_fail++;
      $display("FAIL slew_best: got %0d/%0d/%0d, want 1/6/100",
               bus.best_prn, bus.best_phase, bus.best_power);
    end
  endtask

  task automatic test_ties();
    bit ok;
    fill_pw(9, 9);
    plan(2, 4);
    tick_pct = 70; corr_k = $urandom_range(4, 1);
    pulse_start(2, 4);
    wait_done(ok);
    n_checks++;
    if (!ok || bus.best_prn !== 5'd2 || bus.best_phase !== 10'd0 || bus.best_power !== 16'd9) begin
      n_fail++;
      $display("FAIL ties_best: got %0d/%0d/%0d (done=%b), want 2/0/9",
               bus.best_prn, bus.best_phase, bus.best_power, ok);
    end
    n_checks++;
    if (hyp_bad(12) !== 0) begin
      n_fail++; $display("FAIL ties_hyps: %0d bad hypotheses, want 0", hyp_bad(12));
    end
  endtask

  task automatic test_boundary();
    bit ok; int mp, mh, mw, n0;
    fill_pw(1, 500);
    plan(31, 31);
    tick_pct = 50; corr_k = 3;
    pulse_start(31, 31);
    wait_done(ok);
    n0 = obs_prn.size();
    repeat (60) @(negedge clock);
    model_best(exp_pw.size(), mp, mh, mw);
    n_checks++;
    if (!ok || n0 - hyp_base !== 4 || obs_prn.size() !== n0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prn31_dumps: got %0d then %0d busy=%b, want 4 then 4 busy=0",
               n0 - hyp_base, obs_prn.size() - hyp_base, bus.busy);
    end
    n_checks++;
    if (hyp_bad(4) !== 0 || bus.best_prn !== 5'(mp) || bus.best_phase !== 10'(mh) ||
        bus.best_power !== 16'(mw)) begin
      n_fail++;
      $display("FAIL prn31_best: got %0d/%0d/%0d bad=%0d, want %0d/%0d/%0d bad=0",
               bus.best_prn, bus.best_phase, bus.best_power, hyp_bad(4), mp, mh, mw);
    end

    plan(3, 2);
    pulse_start(3, 2);
    @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1 || bus.best_power !== 16'd0 || bus.best_prn !== 5'd0 ||
        bus.best_phase !== 10'd0) begin
      n_fail++;
      $display("FAIL empty_range: got done=%b best=%0d/%0d/%0d, want done=1 best=0/0/0",
               bus.done, bus.best_prn, bus.best_phase, bus.best_power);
    end
    @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || obs_prn.size() !== hyp_base) begin
      n_fail++;
      $display("FAIL empty_range_after: got done=%b busy=%b dumps=%0d, want 0 0 0",
               bus.done, bus.busy, obs_prn.size() - hyp_base);
    end
  endtask

  task automatic test_abort();
    bit ok; int dc0, mp, mh, mw;
    fill_pw(1, 300);
    plan(10, 11);
    tick_pct = 50; corr_k = 2; corr_limit = 2; dc0 = done_cnt;
    pulse_start(10, 11);
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(posedge clock);
      if (obs_prn.size() >= hyp_base + 3) ok = 1'b1;
    end
    #1 bus.abort = 1'b1;
    @(posedge clock);
    #1 bus.abort = 1'b0;
    @(negedge clock);
    n_checks++;
    if (!ok || bus.busy !== 1'b0 || bus.ca_reset !== 1'b1 || bus.ca_clock_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got reached=%b busy=%b rst=%b en=%b, want 1 0 1 0",
               ok, bus.busy, bus.ca_reset, bus.ca_clock_en);
    end
    repeat (40) @(negedge clock);
    model_best(2, mp, mh, mw);
    n_checks++;
    if (done_cnt !== dc0 || obs_prn.size() - hyp_base !== 3) begin
      n_fail++;
      $display("FAIL abort_quiet: got done=%0d dumps=%0d, want 0 3", done_cnt - dc0,
               obs_prn.size() - hyp_base);
    end
    n_checks++;
    if (bus.best_prn !== 5'(mp) || bus.best_phase !== 10'(mh) || bus.best_power !== 16'(mw)) begin
      n_fail++;
      $display("FAIL abort_partial: got %0d/%0d/%0d, want %0d/%0d/%0d",
               bus.best_prn, bus.best_phase, bus.best_power, mp, mh, mw);
    end
    corr_limit = 1 << 30;
  endtask

  task automatic test_stray_and_busy_start();
    bit ok; int mp, mh, mw, s0, dc0;
    fill_pw(1, 200);
    plan(7, 8);
    tick_pct = 50; corr_k = 1; s0 = stray_cnt; stray_max = stray_cnt + 1; dc0 = done_cnt;
    pulse_start(7, 8);
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(posedge clock);
      if (obs_prn.size() >= hyp_base + 2) ok = 1'b1;
    end
    pulse_start(0, 0);
    wait_done(ok);
    repeat (3) @(negedge clock);
    model_best(exp_pw.size(), mp, mh, mw);
    n_checks++;
    if (stray_cnt - s0 !== 1) begin
      n_fail++; $display("FAIL stray_injected: got %0d strays, want 1", stray_cnt - s0);
    end
    n_checks++;
    if (!ok || obs_prn.size() - hyp_base !== 8 || hyp_bad(8) !== 0 || done_cnt - dc0 !== 1) begin
      n_fail++;
      $display("FAIL busy_start: got dumps=%0d bad=%0d done=%0d, want 8 0 1",
               obs_prn.size() - hyp_base, hyp_bad(8), done_cnt - dc0);
    end
    n_checks++;
    if (bus.best_prn !== 5'(mp) || bus.best_phase !== 10'(mh) || bus.best_power !== 16'(mw)) begin
      n_fail++;
      $display("FAIL stray_best: got %0d/%0d/%0d, want %0d/%0d/%0d",
               bus.best_prn, bus.best_phase, bus.best_power, mp, mh, mw);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int mp, mh, mw;
    fill_pw(1, 1000);
    plan(20, 20);
    tick_pct = 80; corr_k = 2;
    pulse_start(20, 20);
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clock);
      if (bus.done) ok = 1'b1;
    end
    bus.start = 1'b1; bus.prn_first = 5'd0; bus.prn_last = 5'd0;
    @(posedge clock);
    #1 bus.start = 1'b0;
    @(negedge clock);
    model_best(exp_pw.size(), mp, mh, mw);
    n_checks++;
    if (!ok || bus.busy !== 1'b0 || bus.best_power !== 16'(mw) || bus.best_prn !== 5'(mp)) begin
      n_fail++;
      $display("FAIL start_on_done: got done=%b busy=%b best=%0d/%0d, want 1 0 %0d/%0d",
               ok, bus.busy, bus.best_prn, bus.best_power, mp, mw);
    end
    plan(21, 21);
    pulse_start(21, 21);
    wait_done(ok);
    model_best(exp_pw.size(), mp, mh, mw);
    n_checks++;
    if (!ok || hyp_bad(4) !== 0 || bus.best_prn !== 5'(mp) || bus.best_phase !== 10'(mh) ||
        bus.best_power !== 16'(mw)) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d/%0d/%0d bad=%0d, want %0d/%0d/%0d bad=0",
               bus.best_prn, bus.best_phase, bus.best_power, hyp_bad(4), mp, mh, mw);
    end
    n_checks++;
    if (overlap_err !== 0) begin
      n_fail++; $display("FAIL reset_en_overlap: got %0d cycles, want 0", overlap_err);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.prn_first = '0; bus.prn_last = '0;
    test_reset();
    test_single();
    test_slew_order();
    test_ties();
    test_boundary();
    test_abort();
    test_stray_and_busy_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
